// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: frame sequencer for a serial CCITT CRC LFSR.
// Takes DATA_W-bit words over valid/ready and feeds them one bit per clock
// into the LFSR. At frame end it captures the LFSR state and pulses done.
// Optional build macro CRC_CTRL_CHECK_EN adds crc_expect/crc_ok compare.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | one cycle, LFSR reinitialised (crc_enable+crc_init)
// LOAD   | s_ready high, waiting for the next word; LFSR holds
// SHIFT  | one bit per cycle into the LFSR
// SETTLE | LFSR holds the final value; capture it, pulse done next cycle
module crc_frame_ctrl #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              crc_enable,
    output logic              crc_init,
    output logic              crc_data,
    input  logic [15:0]       crc_in,
    output logic [15:0]       crc_result,
    output logic              done,
    output logic              busy,
`ifdef CRC_CTRL_CHECK_EN
    input  logic [15:0]       crc_expect,
    output logic              crc_ok,
`endif
    output logic [CNT_W-1:0]  word_cnt
);

    // bit_cnt must stay at least one bit wide when DATA_W is 1
    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        LOAD   = 3'd2,
        SHIFT  = 3'd3,
        SETTLE = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [BC_W-1:0]   bit_cnt;
    logic              last_q;
    logic              head_bit;

    assign head_bit = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and LFSR/stream strobes; abort overrides any transition
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        crc_enable = 1'b0;
        crc_init   = 1'b0;
        crc_data   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) state_nxt = INIT;
            end
            INIT: begin
                crc_enable = 1'b1;
                crc_init   = 1'b1;
                state_nxt  = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                crc_enable = 1'b1;
                crc_data   = head_bit;
                if (bit_cnt == '0) state_nxt = last_q ? SETTLE : LOAD;
            end
            SETTLE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort && (state != IDLE)) state_nxt = IDLE;
    end

    // Word capture, bit serialisation, counters and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            last_q     <= 1'b0;
            word_cnt   <= '0;
            crc_result <= 16'h0000;
            done       <= 1'b0;
`ifdef CRC_CTRL_CHECK_EN
            crc_ok     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                INIT: begin
                    word_cnt <= '0;
`ifdef CRC_CTRL_CHECK_EN
                    crc_ok   <= 1'b0;
`endif
                end
                LOAD: begin
                    if (s_valid && !abort) begin
                        shreg   <= s_data;
                        last_q  <= s_last;
                        bit_cnt <= BC_W'(DATA_W - 1);
                        if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!abort) begin
                        shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                        if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (!abort) begin
                        crc_result <= crc_in;
                        done       <= 1'b1;
`ifdef CRC_CTRL_CHECK_EN
                        crc_ok     <= (crc_in == crc_expect);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Testbench for crc_frame_ctrl. Two instances share the stimulus: one
// MSB-first with a 16-bit word counter, one LSB-first with a 2-bit word
// counter (exercises saturation). Each drives its own behavioural LFSR.
// The LFSR takes the data bit in at bit 0: next = {crc[14:0], d} ^ (crc[15] ? 0x1021 : 0).
module tb_crc_frame_ctrl;

    typedef logic [7:0] word_q_t[$];

    typedef struct {
        int          n;
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          gap;
        logic [15:0] exp_m;
        bit          chk_m;
        logic [15:0] exp_l;
        bit          chk_l;
        int          exp_done;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;

    logic        s_ready, crc_enable, crc_init, crc_data, done, busy;
    logic [15:0] crc_result;
    logic [15:0] word_cnt;
    logic [15:0] lfsr_m;

    logic        l_s_ready, l_crc_enable, l_crc_init, l_crc_data, l_done, l_busy;
    logic [15:0] l_crc_result;
    logic [1:0]  l_word_cnt;
    logic [15:0] lfsr_l;

`ifdef CRC_CTRL_CHECK_EN
    logic [15:0] crc_expect_m, crc_expect_l;
    logic        crc_ok, l_crc_ok;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int inv_err  = 0;

    crc_frame_ctrl #(.DATA_W(8), .MSB_FIRST(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .crc_enable(crc_enable), .crc_init(crc_init), .crc_data(crc_data),
        .crc_in(lfsr_m), .crc_result(crc_result), .done(done), .busy(busy),
`ifdef CRC_CTRL_CHECK_EN
        .crc_expect(crc_expect_m), .crc_ok(crc_ok),
`endif
        .word_cnt(word_cnt)
    );

    crc_frame_ctrl #(.DATA_W(8), .MSB_FIRST(1'b0), .CNT_W(2)) dut_lsb (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(l_s_ready), .s_data(s_data), .s_last(s_last),
        .crc_enable(l_crc_enable), .crc_init(l_crc_init), .crc_data(l_crc_data),
        .crc_in(lfsr_l), .crc_result(l_crc_result), .done(l_done), .busy(l_busy),
`ifdef CRC_CTRL_CHECK_EN
        .crc_expect(crc_expect_l), .crc_ok(l_crc_ok),
`endif
        .word_cnt(l_word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural LFSRs driven by each controller's strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_m <= 16'h0000;
            lfsr_l <= 16'h0000;
        end else begin
            if (crc_enable)
                lfsr_m <= crc_init ? 16'hFFFF
                        : ({lfsr_m[14:0], crc_data} ^ (lfsr_m[15] ? 16'h1021 : 16'h0000));
            if (l_crc_enable)
                lfsr_l <= l_crc_init ? 16'hFFFF
                        : ({lfsr_l[14:0], l_crc_data} ^ (lfsr_l[15] ? 16'h1021 : 16'h0000));
        end
    end

    // Reference CRC of a whole frame, from the message bit sequence
    function automatic logic [15:0] ref_crc(input word_q_t w, input bit msb_first);
        logic [15:0] c;
        logic        b;
        c = 16'hFFFF;
        foreach (w[k]) begin
            for (int i = 0; i < 8; i++) begin
                b = msb_first ? w[k][7-i] : w[k][i];
                c = {c[14:0], b} ^ (c[15] ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Runs one frame from IDLE; done_cyc is -1 if done never came
    task automatic run_frame(input word_q_t words, input int gap_idx, input int gap_len,
                             input int stall_pct, output int done_cyc, output int stalls);
        int idx;
        int gap_left;
        done_cyc = -1;
        stalls   = 0;
        idx      = 0;
        gap_left = gap_len;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (s_ready && crc_enable) inv_err++;
            if (crc_init && (cyc != 1 || !crc_enable)) inv_err++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (s_ready) begin
                if (idx == gap_idx && gap_left > 0) begin
                    s_valid = 1'b0;
                    gap_left--;
                    stalls++;
                end else if ($urandom_range(99) < stall_pct) begin
                    s_valid = 1'b0;
                    stalls++;
                end else begin
                    s_valid = 1'b1;
                    s_data  = (idx < words.size()) ? words[idx] : 8'h00;
                    s_last  = (idx >= words.size() - 1);
                    idx++;
                end
            end else begin
                s_valid = 1'($urandom_range(1));
                s_data  = 8'($urandom);
                s_last  = 1'($urandom_range(1));
            end
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    vec_t        vecs[5];
    word_q_t     wq;
    int          dcyc, stalls, exp_done, exp_cnt;
    logic [15:0] exp_m, exp_l, last_m, last_l;
    int          nshift;
    bit          found, saw_done;

    initial begin
        vecs[0] = '{1, 8'h00, 8'h00, 0, 16'hE1F0, 1'b1, 16'hE1F0, 1'b1, 12};
        vecs[1] = '{2, 8'h00, 8'h00, 0, 16'h1D0F, 1'b1, 16'h1D0F, 1'b1, 21};
        vecs[2] = '{1, 8'h80, 8'h00, 0, 16'hE170, 1'b1, 16'h0000, 1'b0, 12};
        vecs[3] = '{1, 8'h01, 8'h00, 0, 16'h0000, 1'b0, 16'hE170, 1'b1, 12};
        vecs[4] = '{2, 8'h00, 8'h00, 5, 16'h1D0F, 1'b1, 16'h1D0F, 1'b1, 26};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
`ifdef CRC_CTRL_CHECK_EN
        crc_expect_m = 16'h0000; crc_expect_l = 16'h0000;
`endif
        step(); step();
        chk("reset_strobes", {s_ready, crc_enable, crc_init, crc_data, done, busy}, 0);
        chk("reset_result", crc_result, 0);
        chk("reset_word_cnt", word_cnt, 0);
`ifdef CRC_CTRL_CHECK_EN
        chk("reset_crc_ok", crc_ok, 0);
`endif
        reset = 1'b0;
        step();

        // Directed vectors
        for (int v = 0; v < 5; v++) begin
            wq = {};
            wq.push_back(vecs[v].w0);
            if (vecs[v].n > 1) wq.push_back(vecs[v].w1);
            exp_m = vecs[v].chk_m ? vecs[v].exp_m : ref_crc(wq, 1'b1);
            exp_l = vecs[v].chk_l ? vecs[v].exp_l : ref_crc(wq, 1'b0);
`ifdef CRC_CTRL_CHECK_EN
            crc_expect_m = (v % 2 == 0) ? exp_m : (exp_m ^ 16'h0001);
            crc_expect_l = exp_l;
`endif
            inv_err = 0;
            run_frame(wq, 1, vecs[v].gap, 0, dcyc, stalls);
            chk($sformatf("vec%0d_done_cycle", v), dcyc, vecs[v].exp_done);
            chk($sformatf("vec%0d_crc_msb", v), crc_result, exp_m);
            chk($sformatf("vec%0d_crc_lsb", v), l_crc_result, exp_l);
            chk($sformatf("vec%0d_word_cnt", v), word_cnt, vecs[v].n);
            chk($sformatf("vec%0d_busy_at_done", v), busy, 0);
`ifdef CRC_CTRL_CHECK_EN
            chk($sformatf("vec%0d_crc_ok", v), crc_ok, (v % 2 == 0) ? 1 : 0);
            chk($sformatf("vec%0d_crc_ok_lsb", v), l_crc_ok, 1);
`endif
            step();
            chk($sformatf("vec%0d_done_pulse", v), done, 0);
            chk($sformatf("vec%0d_invariants", v), inv_err, 0);
            last_m = exp_m;
            last_l = exp_l;
        end

        // Random frames, including stalls and word counts past 2-bit saturation
        for (int f = 0; f < 20; f++) begin
            wq = {};
            for (int k = 0; k < int'($urandom_range(5, 1)); k++) wq.push_back(8'($urandom));
            exp_m    = ref_crc(wq, 1'b1);
            exp_l    = ref_crc(wq, 1'b0);
            exp_cnt  = wq.size();
`ifdef CRC_CTRL_CHECK_EN
            crc_expect_m = exp_m;
            crc_expect_l = exp_l ^ 16'h8000;
`endif
            inv_err = 0;
            run_frame(wq, -1, 0, 30, dcyc, stalls);
            exp_done = 9 * exp_cnt + 3 + stalls;
            chk($sformatf("rnd%0d_done_cycle", f), dcyc, exp_done);
            chk($sformatf("rnd%0d_crc_msb", f), crc_result, exp_m);
            chk($sformatf("rnd%0d_crc_lsb", f), l_crc_result, exp_l);
            chk($sformatf("rnd%0d_word_cnt", f), word_cnt, exp_cnt);
            chk($sformatf("rnd%0d_word_cnt_sat", f), l_word_cnt, (exp_cnt > 3) ? 3 : exp_cnt);
`ifdef CRC_CTRL_CHECK_EN
            chk($sformatf("rnd%0d_crc_ok", f), {crc_ok, l_crc_ok}, 2'b10);
`endif
            chk($sformatf("rnd%0d_invariants", f), inv_err, 0);
            last_m = exp_m;
            last_l = exp_l;
            step();
        end

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        chk("start_abort_idle", {busy, l_busy}, 0);

        // abort in the third SHIFT cycle
        start = 1'b1;
        step();
        start = 1'b0;
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b1;
        nshift = 0; found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (crc_enable && !crc_init) nshift++;
            if (nshift == 3) begin
                abort = 1'b1;
                found = 1'b1;
                step();
                abort = 1'b0;
                break;
            end
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("abort_reached_shift3", found, 1);
        chk("abort_idle_next", {busy, crc_enable, s_ready}, 0);
        saw_done = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (done || l_done || busy) saw_done = 1'b1;
            step();
        end
        chk("abort_no_done", saw_done, 0);
        chk("abort_result_kept", crc_result, last_m);
        chk("abort_result_kept_lsb", l_crc_result, last_l);

        // fresh frame after abort
        wq = {};
        wq.push_back(8'($urandom)); wq.push_back(8'($urandom));
        exp_m = ref_crc(wq, 1'b1);
`ifdef CRC_CTRL_CHECK_EN
        crc_expect_m = exp_m;
`endif
        run_frame(wq, -1, 0, 0, dcyc, stalls);
        chk("post_abort_done_cycle", dcyc, 21);
        chk("post_abort_crc", crc_result, exp_m);
        step();

        // reset in the middle of a frame
        start = 1'b1;
        step();
        start = 1'b0;
        s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
        for (int c = 0; c < 6; c++) step();
        reset = 1'b1;
        s_valid = 1'b0;
        step();
        chk("midreset_strobes", {s_ready, crc_enable, crc_init, crc_data, done, busy}, 0);
        chk("midreset_result", crc_result, 0);
        chk("midreset_word_cnt", word_cnt, 0);
`ifdef CRC_CTRL_CHECK_EN
        chk("midreset_crc_ok", crc_ok, 0);
`endif
        reset = 1'b0;
        step();

        wq = {};
        wq.push_back(8'h00);
        run_frame(wq, -1, 0, 0, dcyc, stalls);
        chk("post_reset_done_cycle", dcyc, 12);
        chk("post_reset_crc", crc_result, 16'hE1F0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
